// File: rtl/key_entry_shifter_if.sv
// key_entry_shifter_if
//   Bundles the key-entry data path between the priority-encoder/button side
//   and the digit-display side of key_entry_shifter.
//   Signals:
//     code[3:0]          priority-encoder output
//     strobe             priority-encoder valid flag
//     clr                level clear of the entry buffer
//     bksp               backspace button (only with KEY_ENTRY_BACKSPACE_EN)
//     digits[4*N-1:0]    digit i at [4i+3:4i], digit 0 newest
//     enables[N-1:0]     per-digit enables for the ssdec instances
//     count              number of valid digits
//     press              one-cycle pulse per committed digit
//   Modports: master drives code/strobe/clr/bksp, slave (the shifter) drives
//   the display outputs.
//   Optional feature macro: KEY_ENTRY_BACKSPACE_EN.
interface key_entry_shifter_if #(
  parameter int NDIGITS = 8
);
  localparam int CW = $clog2(NDIGITS + 1);

  logic [3:0]           code;
  logic                 strobe;
  logic                 clr;
`ifdef KEY_ENTRY_BACKSPACE_EN
  logic                 bksp;
`endif
  logic [4*NDIGITS-1:0] digits;
  logic [NDIGITS-1:0]   enables;
  logic [CW-1:0]        count;
  logic                 press;

`ifdef KEY_ENTRY_BACKSPACE_EN
  modport master (output code, strobe, clr, bksp,
                  input  digits, enables, count, press);
  modport slave  (input  code, strobe, clr, bksp,
                  output digits, enables, count, press);
`else
  modport master (output code, strobe, clr,
                  input  digits, enables, count, press);
  modport slave  (input  code, strobe, clr,
                  output digits, enables, count, press);
`endif
endinterface

// File: rtl/key_entry_shifter.sv
// key_entry_shifter
//   Synchronises and debounces presses from a 16-to-4 push-button priority
//   encoder, commits one hex digit per press into an NDIGITS-deep nibble
//   shift register and drives per-digit enables for seven-segment decoders.
//   Ports:
//     hz100   in   system clock, all state updates on posedge
//     reset   in   synchronous active-high reset
//     kbus    key_entry_shifter_if.slave (code, strobe, clr, [bksp] in;
//             digits, enables, count, press out)
//   Parameters:
//     NDIGITS          digits held
//     DEBOUNCE_CYCLES  stable-high cycles needed before commit (>= 1)
//   Optional feature macro: KEY_ENTRY_BACKSPACE_EN enables the backspace
//   input; when undefined there is no backspace logic at all.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   S_IDLE     | no key down, waiting for synced strobe
//   S_DEBOUNCE | key seen, counting stable cycles of the same code
//   S_HELD     | digit committed, waiting for release (no auto-repeat)
module key_entry_shifter #(
  parameter int NDIGITS         = 8,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic                hz100,
  input  logic                reset,
  key_entry_shifter_if.slave  kbus
);
  localparam int CW   = $clog2(NDIGITS + 1);
  localparam int DGW  = 4 * NDIGITS;
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NDIGITS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  logic          strobe_m_q, strobe_s_q;
  logic [3:0]    code_m_q, code_s_q;

  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          commit_q, commit_d;

  logic [DGW-1:0] digits_q, digits_d;
  logic [CW-1:0]  count_q, count_d;
  logic           press_q, press_d;

`ifdef KEY_ENTRY_BACKSPACE_EN
  logic bksp_m_q, bksp_s_q, bksp_p_q;
  logic bksp_rise;
  assign bksp_rise = bksp_s_q & ~bksp_p_q;
`endif

  // Two-flop synchronisers on the asynchronous button inputs.
  always_ff @(posedge hz100) begin
    if (reset) begin
      strobe_m_q <= 1'b0;
      strobe_s_q <= 1'b0;
      code_m_q   <= 4'h0;
      code_s_q   <= 4'h0;
`ifdef KEY_ENTRY_BACKSPACE_EN
      bksp_m_q   <= 1'b0;
      bksp_s_q   <= 1'b0;
      bksp_p_q   <= 1'b0;
`endif
    end else begin
      strobe_m_q <= kbus.strobe;
      strobe_s_q <= strobe_m_q;
      code_m_q   <= kbus.code;
      code_s_q   <= code_m_q;
`ifdef KEY_ENTRY_BACKSPACE_EN
      bksp_m_q   <= kbus.bksp;
      bksp_s_q   <= bksp_m_q;
      bksp_p_q   <= bksp_s_q;
`endif
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cand_q   <= 4'h0;
      dcnt_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      dcnt_q   <= dcnt_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    dcnt_d   = dcnt_q;
    commit_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (strobe_s_q) begin
          cand_d  = code_s_q;
          dcnt_d  = '0;
          state_d = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!strobe_s_q) begin
          state_d = S_IDLE;
        end else if (code_s_q != cand_q) begin
          // Code moved while still bouncing: restart on the new code.
          cand_d = code_s_q;
          dcnt_d = '0;
        end else if (dcnt_q == DC_LAST) begin
          commit_d = 1'b1;
          state_d  = S_HELD;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_HELD: begin
        if (!strobe_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer update one cycle after the FSM decides to commit; cand_q is frozen
  // in S_HELD so it is still the committed digit. clr wins over commit, which
  // wins over backspace; losers are dropped.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    press_d  = 1'b0;
    if (kbus.clr) begin
      digits_d = '0;
      count_d  = '0;
    end else if (commit_q) begin
      digits_d = (digits_q << 4) | DGW'(cand_q);
      count_d  = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);
      press_d  = 1'b1;
    end
`ifdef KEY_ENTRY_BACKSPACE_EN
    else if (bksp_rise && (count_q != '0)) begin
      digits_d = digits_q >> 4;
      count_d  = count_q - CW'(1);
    end
`endif
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      digits_q <= '0;
      count_q  <= '0;
      press_q  <= 1'b0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      press_q  <= press_d;
    end
  end

  logic [NDIGITS-1:0] enables_c;
  always_comb begin
    enables_c = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      enables_c[i] = (count_q > CW'(i));
    end
  end

  assign kbus.digits  = digits_q;
  assign kbus.count   = count_q;
  assign kbus.press   = press_q;
  assign kbus.enables = enables_c;

endmodule
